// File: rtl/dmem_axi_line_master.sv
// Cache-line fill/writeback master: one line request becomes one AXI4 INCR burst
// on the HP0 port, with a single outstanding transaction and a fixed ID.
module dmem_axi_line_master #(
    parameter int ADDR_W     = 49,
    parameter int DATA_W     = 128,
    parameter int ID_W       = 6,
    parameter int LINE_BEATS = 4,
    parameter int AXI_ID     = 0
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [LINE_BEATS*DATA_W-1:0] req_wdata,
    output logic                         resp_valid,
    output logic [LINE_BEATS*DATA_W-1:0] resp_rdata,
    output logic                         resp_err,
    output logic                         ARVALID,
    input  logic                         ARREADY,
    output logic [ADDR_W-1:0]            ARADDR,
    output logic [7:0]                   ARLEN,
    output logic [2:0]                   ARSIZE,
    output logic [1:0]                   ARBURST,
    output logic [ID_W-1:0]              ARID,
    output logic [3:0]                   ARCACHE,
    output logic [2:0]                   ARPROT,
    output logic [3:0]                   ARQOS,
    output logic                         ARLOCK,
    output logic                         ARUSER,
    input  logic                         RVALID,
    output logic                         RREADY,
    input  logic [DATA_W-1:0]            RDATA,
    input  logic [1:0]                   RRESP,
    input  logic                         RLAST,
    input  logic [ID_W-1:0]              RID,
    output logic                         AWVALID,
    input  logic                         AWREADY,
    output logic [ADDR_W-1:0]            AWADDR,
    output logic [7:0]                   AWLEN,
    output logic [2:0]                   AWSIZE,
    output logic [1:0]                   AWBURST,
    output logic [ID_W-1:0]              AWID,
    output logic [3:0]                   AWCACHE,
    output logic [2:0]                   AWPROT,
    output logic [3:0]                   AWQOS,
    output logic                         AWLOCK,
    output logic                         AWUSER,
    output logic                         WVALID,
    input  logic                         WREADY,
    output logic [DATA_W-1:0]            WDATA,
    output logic [DATA_W/8-1:0]          WSTRB,
    output logic                         WLAST,
    input  logic                         BVALID,
    output logic                         BREADY,
    input  logic [1:0]                   BRESP,
    input  logic [ID_W-1:0]              BID
);

    localparam int LINE_W = LINE_BEATS * DATA_W;
    localparam int OFF_W  = $clog2(LINE_W / 8);
    localparam int CNT_W  = $clog2(LINE_BEATS) + 1;
    localparam logic [ADDR_W-1:0] ADDR_MASK = ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0]  NUM_BEATS = CNT_W'(LINE_BEATS);
    localparam logic [ID_W-1:0]   ID        = ID_W'(AXI_ID);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, RESP} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  line_addr;
    logic [LINE_W-1:0]  wdata_line;
    logic [LINE_W-1:0]  fill_buf;
    logic [LINE_W-1:0]  fill_next;
    logic [CNT_W-1:0]   beat_cnt;
    logic               err;
    logic               aw_done;
    logic               w_done;

    logic accept, r_fire, r_store, r_err, aw_fire, w_fire, w_last_fire, b_err;
    logic unused_resp_bits;

    assign accept      = (state == IDLE) && req_valid && req_ready;
    assign r_fire      = RVALID && RREADY;
    assign r_store     = r_fire && (beat_cnt < NUM_BEATS);
    assign aw_fire     = AWVALID && AWREADY;
    assign w_fire      = WVALID && WREADY;
    assign w_last_fire = w_fire && WLAST;

    // A beat is in error if flagged, mis-tagged, or RLAST lands off the last slot.
    assign r_err = RRESP[1] || (RID != ID) ||
                   (RLAST ? (beat_cnt != LAST_BEAT) : (beat_cnt >= LAST_BEAT));
    assign b_err = BRESP[1] || (BID != ID);
    assign unused_resp_bits = &{1'b0, RRESP[0], BRESP[0]};

    assign ARADDR  = line_addr;
    assign ARLEN   = 8'(LINE_BEATS - 1);
    assign ARSIZE  = 3'($clog2(DATA_W / 8));
    assign ARBURST = 2'b01;
    assign ARID    = ID;
    assign ARCACHE = 4'b0011;
    assign ARPROT  = 3'b000;
    assign ARQOS   = 4'b0000;
    assign ARLOCK  = 1'b0;
    assign ARUSER  = 1'b0;
    assign AWADDR  = line_addr;
    assign AWLEN   = 8'(LINE_BEATS - 1);
    assign AWSIZE  = 3'($clog2(DATA_W / 8));
    assign AWBURST = 2'b01;
    assign AWID    = ID;
    assign AWCACHE = 4'b0011;
    assign AWPROT  = 3'b000;
    assign AWQOS   = 4'b0000;
    assign AWLOCK  = 1'b0;
    assign AWUSER  = 1'b0;
    assign WSTRB   = '1;
    assign WLAST   = (beat_cnt == LAST_BEAT);

    always_comb begin
        fill_next = fill_buf;
        for (int b = 0; b < LINE_BEATS; b++) begin
            if (r_store && beat_cnt == CNT_W'(b)) fill_next[b*DATA_W +: DATA_W] = RDATA;
        end
    end

    always_comb begin
        WDATA = '0;
        for (int b = 0; b < LINE_BEATS; b++) begin
            if (beat_cnt == CNT_W'(b)) WDATA = wdata_line[b*DATA_W +: DATA_W];
        end
    end

    // Datapath captures carry no reset; they are qualified by the control state.
    always_ff @(posedge ACLK) begin
        if (accept) begin
            line_addr  <= req_addr & ADDR_MASK;
            wdata_line <= req_wdata;
        end
        if (r_fire) fill_buf <= fill_next;
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            ARVALID    <= 1'b0;
            RREADY     <= 1'b0;
            AWVALID    <= 1'b0;
            WVALID     <= 1'b0;
            BREADY     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            beat_cnt   <= '0;
            err        <= 1'b0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        err       <= 1'b0;
                        beat_cnt  <= '0;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (req_write) begin
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                            state   <= WR;
                        end else begin
                            ARVALID <= 1'b1;
                            state   <= RD_ADDR;
                        end
                    end
                end
                RD_ADDR: begin
                    if (ARVALID && ARREADY) begin
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    // Beats past the line end are drained but not stored.
                    if (r_fire) begin
                        err <= err | r_err;
                        if (beat_cnt < NUM_BEATS) beat_cnt <= beat_cnt + 1'b1;
                        if (RLAST) begin
                            RREADY     <= 1'b0;
                            resp_valid <= 1'b1;
                            resp_err   <= err | r_err;
                            resp_rdata <= fill_next;
                            state      <= RESP;
                        end
                    end
                end
                WR: begin
                    if (aw_fire) begin
                        AWVALID <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_fire) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (WLAST) begin
                            WVALID <= 1'b0;
                            w_done <= 1'b1;
                        end
                    end
                    if ((aw_done || aw_fire) && (w_done || w_last_fire)) begin
                        BREADY <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY     <= 1'b0;
                        err        <= err | b_err;
                        resp_valid <= 1'b1;
                        resp_err   <= err | b_err;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    req_ready  <= 1'b1;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_axi_line_master.sv
// Bench for dmem_axi_line_master: a task-driven AXI slave with randomized waits
// and a line-level reference model of the expected bursts and responses.
`timescale 1ns/1ps
module tb_dmem_axi_line_master;

    localparam int ADDR_W     = 49;
    localparam int DATA_W     = 128;
    localparam int ID_W       = 6;
    localparam int LB         = 4;
    localparam int AXI_ID     = 0;
    localparam int LINE_W     = LB * DATA_W;
    localparam int LINE_BYTES = LINE_W / 8;

    logic ACLK = 1'b0;
    logic ARESETn = 1'b0;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LINE_W-1:0] req_wdata = '0;
    logic resp_valid, resp_err;
    logic [LINE_W-1:0] resp_rdata;
    logic ARVALID, ARREADY = 1'b0;
    logic [ADDR_W-1:0] ARADDR, AWADDR;
    logic [7:0] ARLEN, AWLEN;
    logic [2:0] ARSIZE, AWSIZE, ARPROT, AWPROT;
    logic [1:0] ARBURST, AWBURST;
    logic [ID_W-1:0] ARID, AWID;
    logic [3:0] ARCACHE, AWCACHE, ARQOS, AWQOS;
    logic ARLOCK, AWLOCK, ARUSER, AWUSER;
    logic RVALID = 1'b0, RREADY, RLAST = 1'b0;
    logic [DATA_W-1:0] RDATA = '0;
    logic [1:0] RRESP = 2'b00;
    logic [ID_W-1:0] RID = '0;
    logic AWVALID, AWREADY = 1'b0;
    logic WVALID, WREADY = 1'b0, WLAST;
    logic [DATA_W-1:0] WDATA;
    logic [DATA_W/8-1:0] WSTRB;
    logic BVALID = 1'b0, BREADY;
    logic [1:0] BRESP = 2'b00;
    logic [ID_W-1:0] BID = '0;

    dmem_axi_line_master #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LINE_BEATS(LB), .AXI_ID(AXI_ID)
    ) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARLEN(ARLEN),
        .ARSIZE(ARSIZE), .ARBURST(ARBURST), .ARID(ARID), .ARCACHE(ARCACHE),
        .ARPROT(ARPROT), .ARQOS(ARQOS), .ARLOCK(ARLOCK), .ARUSER(ARUSER),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .RLAST(RLAST), .RID(RID),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWLEN(AWLEN),
        .AWSIZE(AWSIZE), .AWBURST(AWBURST), .AWID(AWID), .AWCACHE(AWCACHE),
        .AWPROT(AWPROT), .AWQOS(AWQOS), .AWLOCK(AWLOCK), .AWUSER(AWUSER),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID)
    );

    always #5 ACLK = ~ACLK;

    int cyc = 0;
    always @(posedge ACLK) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    logic [LINE_W-1:0] ref_line = '0;
    bit ref_known = 1'b1;

    task automatic chk(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_beat();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [ADDR_W-1:0] exp_addr(input logic [ADDR_W-1:0] a);
        return a - (a % ADDR_W'(LINE_BYTES));
    endfunction

    // Present a request at the current falling edge and hold until it is taken.
    task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd,
                         output int acc);
        int n = 0;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd;
        while (!req_ready && n < 50) begin @(negedge ACLK); n++; end
        chk("req_ready_wait", req_ready, 1);
        acc = cyc;
        @(negedge ACLK);
        req_valid = 1'b0;
        req_addr  = ADDR_W'({$urandom, $urandom});
        req_wdata = {LB{rnd_beat()}};
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic wait_resp(input int acc, input bit exp_err, input bit chk_data, input bit chk_lat);
        int n = 0;
        while (!resp_valid && n < 200) begin @(negedge ACLK); n++; end
        chk("resp_valid", resp_valid, 1);
        chk("resp_err", resp_err, exp_err);
        if (chk_data) chk("resp_rdata", resp_rdata, ref_line);
        if (chk_lat) chk("latency", cyc - acc, LB + 2);
        @(negedge ACLK);
        chk("resp_pulse", resp_valid, 0);
        chk("req_ready_back", req_ready, 1);
        if (chk_data) chk("rdata_hold", resp_rdata, ref_line);
    endtask

    task automatic do_read(input logic [ADDR_W-1:0] a, input int nbeats, input int ar_dly,
                           input int gap_max, input int err_beat, input int badid_beat,
                           input bit pat, input bit chk_lat);
        int acc;
        int n = 0;
        bit exp_err = (nbeats != LB);
        logic [DATA_W-1:0] d;
        logic [LINE_W-1:0] line = ref_line;
        issue(1'b0, a, '0, acc);
        while (!ARVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("arvalid", ARVALID, 1);
        chk("araddr", ARADDR, exp_addr(a));
        chk("arlen", ARLEN, LB - 1);
        chk("arsize", ARSIZE, 4);
        chk("arburst", ARBURST, 1);
        chk("arid", ARID, AXI_ID);
        chk("arcache", ARCACHE, 4'b0011);
        chk("ar_misc", {ARPROT, ARQOS, ARLOCK, ARUSER}, 0);
        for (int i = 0; i < ar_dly; i++) begin
            @(negedge ACLK);
            chk("ar_hold", ARVALID, 1);
            chk("ar_stable", ARADDR, exp_addr(a));
        end
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        chk("ar_drop", ARVALID, 0);
        for (int b = 0; b < nbeats; b++) begin
            int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
            RVALID = 1'b0;
            repeat (g) @(negedge ACLK);
            n = 0;
            while (!RREADY && n < 50) begin @(negedge ACLK); n++; end
            chk("rready", RREADY, 1);
            d = pat ? DATA_W'(32'hA0 + b) : rnd_beat();
            RVALID = 1'b1;
            RDATA  = d;
            RLAST  = (b == nbeats - 1);
            RRESP  = (b == err_beat) ? 2'b10 : 2'($urandom_range(1, 0));
            RID    = (b == badid_beat) ? ID_W'(AXI_ID + 1 + $urandom_range(5, 0)) : ID_W'(AXI_ID);
            if (b == err_beat || b == badid_beat) exp_err = 1'b1;
            if (b < LB) line[b*DATA_W +: DATA_W] = d;
            @(negedge ACLK);
        end
        RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00; RID = '0;
        ref_known = (nbeats >= LB);
        if (ref_known) ref_line = line;
        wait_resp(acc, exp_err, ref_known, chk_lat);
    endtask

    task automatic aw_thread(input logic [ADDR_W-1:0] a, input int dly);
        int n = 0;
        while (!AWVALID && n < 50) begin @(negedge ACLK); n++; end
        chk("awvalid", AWVALID, 1);
        chk("awaddr", AWADDR, exp_addr(a));
        chk("awlen", AWLEN, LB - 1);
        chk("awsize", AWSIZE, 4);
        chk("awburst", AWBURST, 1);
        chk("awid", AWID, AXI_ID);
        chk("awcache", AWCACHE, 4'b0011);
        chk("aw_misc", {AWPROT, AWQOS, AWLOCK, AWUSER}, 0);
        for (int i = 0; i < dly; i++) begin
            @(negedge ACLK);
            chk("aw_hold", AWVALID, 1);
            chk("aw_stable", AWADDR, exp_addr(a));
            chk("bready_early", BREADY, 0);
        end
        AWREADY = 1'b1;
        @(negedge ACLK);
        AWREADY = 1'b0;
        chk("aw_drop", AWVALID, 0);
    endtask

    task automatic w_thread(input logic [LINE_W-1:0] wd, input int mode);
        for (int b = 0; b < LB; b++) begin
            int n = 0;
            int dly = (mode == 0) ? 0 : (mode == 1) ? 1 : int'($urandom_range(2, 0));
            while (!WVALID && n < 50) begin @(negedge ACLK); n++; end
            chk("wvalid", WVALID, 1);
            chk("wdata", WDATA, wd[b*DATA_W +: DATA_W]);
            chk("wlast", WLAST, (b == LB - 1));
            chk("wstrb", WSTRB, {(DATA_W/8){1'b1}});
            for (int i = 0; i < dly; i++) begin
                @(negedge ACLK);
                chk("w_hold", WVALID, 1);
                chk("w_stable", WDATA, wd[b*DATA_W +: DATA_W]);
                chk("bready_early", BREADY, 0);
            end
            WREADY = 1'b1;
            @(negedge ACLK);
            WREADY = 1'b0;
        end
        chk("w_drop", WVALID, 0);
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input int aw_dly, input int w_mode,
                            input int b_dly, input logic [1:0] bresp, input bit bad_bid,
                            input bit chk_lat);
        int acc;
        int n = 0;
        logic [LINE_W-1:0] wd;
        for (int b = 0; b < LB; b++) wd[b*DATA_W +: DATA_W] = rnd_beat();
        issue(1'b1, a, wd, acc);
        fork
            aw_thread(a, aw_dly);
            w_thread(wd, w_mode);
        join
        while (!BREADY && n < 50) begin @(negedge ACLK); n++; end
        chk("bready", BREADY, 1);
        for (int i = 0; i < b_dly; i++) begin
            @(negedge ACLK);
            chk("bready_hold", BREADY, 1);
            chk("no_early_resp", resp_valid, 0);
        end
        BVALID = 1'b1;
        BRESP  = bresp;
        BID    = bad_bid ? ID_W'(AXI_ID + 3) : ID_W'(AXI_ID);
        @(negedge ACLK);
        BVALID = 1'b0; BRESP = 2'b00; BID = '0;
        wait_resp(acc, bresp[1] | bad_bid, ref_known, chk_lat);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk(tag, {req_ready, resp_valid, resp_err, ARVALID, RREADY, AWVALID, WVALID, BREADY}, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc;
        repeat (2) @(negedge ACLK);
        check_idle_outputs("reset_outputs");
        chk("reset_rdata", resp_rdata, 0);
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Directed scenarios
        do_read(49'h1234, LB, 0, 0, -1, -1, 1'b1, 1'b1);
        chk("fill_A0_A3", resp_rdata, {DATA_W'(32'hA3), DATA_W'(32'hA2), DATA_W'(32'hA1), DATA_W'(32'hA0)});
        do_write(49'h4000, 0, 0, 0, 2'b00, 1'b0, 1'b1);
        do_write(49'h4000, 5, 1, 1, 2'b00, 1'b0, 1'b0);
        do_write(49'h4040, 8, 0, 0, 2'b00, 1'b0, 1'b0);
        do_read(49'h2000, LB, 1, 1, 2, -1, 1'b0, 1'b0);
        do_read(49'h0080, LB, 0, 0, -1, -1, 1'b0, 1'b1);
        do_read(49'h3000, 2, 0, 0, -1, -1, 1'b0, 1'b0);
        do_read(49'h3040, LB + 1, 0, 1, -1, -1, 1'b0, 1'b0);
        do_read(49'h3080, LB, 2, 0, -1, -1, 1'b0, 1'b0);
        do_write(49'h5000, 1, 2, 2, 2'b10, 1'b0, 1'b0);
        do_write(49'h5040, 0, 0, 0, 2'b01, 1'b1, 1'b0);
        do_read(49'h6000, LB, 0, 0, -1, 1, 1'b0, 1'b0);

        // Reset in the middle of a fill
        issue(1'b0, 49'h7000, '0, acc);
        ARREADY = 1'b1;
        @(negedge ACLK);
        ARREADY = 1'b0;
        for (int b = 0; b < 2; b++) begin
            RVALID = 1'b1; RDATA = rnd_beat(); RLAST = 1'b0; RRESP = 2'b00; RID = '0;
            @(negedge ACLK);
        end
        #2 ARESETn = 1'b0;
        #1;
        check_idle_outputs("async_reset_outputs");
        chk("async_reset_rdata", resp_rdata, 0);
        RVALID = 1'b0;
        ref_line = '0;
        ref_known = 1'b1;
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            chk("no_resp_after_reset", resp_valid, 0);
        end
        chk("ready_after_reset", req_ready, 1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            logic [ADDR_W-1:0] a = ADDR_W'({$urandom, $urandom});
            if ($urandom_range(1, 0) == 1)
                do_write(a, $urandom_range(4, 0), $urandom_range(2, 0), $urandom_range(3, 0),
                         ($urandom_range(7, 0) == 0) ? 2'b10 : 2'b00,
                         ($urandom_range(9, 0) == 0), 1'b0);
            else
                do_read(a, LB, $urandom_range(3, 0), $urandom_range(2, 0),
                        ($urandom_range(5, 0) == 0) ? int'($urandom_range(LB - 1, 0)) : -1,
                        ($urandom_range(9, 0) == 0) ? int'($urandom_range(LB - 1, 0)) : -1,
                        1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
